// File: rtl/system_reset_sequencer.sv
// Staged reset release for an N-tile system: synchronised board reset, held
// system reset, tile resets released one by one, then per-tile soft reset.
module system_reset_sequencer #(
  parameter int NUM_TILES      = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_TILES-1:0] soft_rst_req,
  output logic                 sys_rst,
  output logic [NUM_TILES-1:0] tile_rst,
  output logic                 all_released,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_CNT = (MAX_HS > SYNC_STAGES) ? MAX_HS : SYNC_STAGES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int TW      = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] STAG_LAST = CW'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

  typedef enum logic [1:0] {SYNC, HOLD, STAGGER, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [TW-1:0]          tile_idx_reg, tile_idx_next;
  logic                   sys_rst_reg, sys_rst_next;
  logic [NUM_TILES-1:0]   tile_rst_reg, tile_rst_next;
  logic                   all_released_reg, all_released_next;
  logic [CNT_WIDTH-1:0]   cycle_count_reg, cycle_count_next;
  logic [NUM_TILES-1:0]   soft_busy;
  logic                   sync_out;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // Per-tile soft reset: a request (re)loads the hold counter; the tile stays
  // in reset while the counter's next value is non-zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TILES; gi++) begin : g_soft
      logic [CW-1:0] soft_cnt_reg, soft_cnt_next;

      always_comb begin
        soft_cnt_next = soft_cnt_reg;
        if (state_reg == RUN) begin
          if (soft_rst_req[gi]) begin
            soft_cnt_next = HOLD_LOAD;
          end else if (soft_cnt_reg != '0) begin
            soft_cnt_next = soft_cnt_reg - CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          soft_cnt_reg <= '0;
        end else begin
          soft_cnt_reg <= soft_cnt_next;
        end
      end

      assign soft_busy[gi] = (soft_cnt_next != '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= SYNC;
      sync_reg         <= '0;
      cnt_reg          <= '0;
      tile_idx_reg     <= '0;
      sys_rst_reg      <= 1'b1;
      tile_rst_reg     <= '1;
      all_released_reg <= 1'b0;
      cycle_count_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      sync_reg         <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
      cnt_reg          <= cnt_next;
      tile_idx_reg     <= tile_idx_next;
      sys_rst_reg      <= sys_rst_next;
      tile_rst_reg     <= tile_rst_next;
      all_released_reg <= all_released_next;
      cycle_count_reg  <= cycle_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    tile_idx_next    = tile_idx_reg;
    sys_rst_next     = sys_rst_reg;
    tile_rst_next    = tile_rst_reg;
    cycle_count_next = cycle_count_reg;

    unique case (state_reg)
      SYNC, HOLD: begin
        // The edge that first sees the synchroniser high is the first hold cycle.
        if (state_reg == HOLD || sync_out) begin
          if (cnt_reg == HOLD_LAST) begin
            sys_rst_next = 1'b0;
            cnt_next     = '0;
            if (STAGGER_CYCLES == 0) begin
              tile_rst_next = '0;
              state_next    = RUN;
            end else begin
              state_next = STAGGER;
            end
          end else begin
            cnt_next   = cnt_reg + CW'(1);
            state_next = HOLD;
          end
        end
      end
      STAGGER: begin
        if (cnt_reg == STAG_LAST) begin
          cnt_next                    = '0;
          tile_rst_next[tile_idx_reg] = 1'b0;
          tile_idx_next               = tile_idx_reg + TW'(1);
          if (tile_idx_reg == LAST_TILE) begin
            state_next = RUN;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RUN: begin
        tile_rst_next = soft_busy;
        if (cycle_count_reg != '1) begin
          cycle_count_next = cycle_count_reg + CNT_WIDTH'(1);
        end
      end
    endcase

    all_released_next = (state_next == RUN) && (tile_rst_next == '0);
  end

  assign sys_rst      = sys_rst_reg;
  assign tile_rst     = tile_rst_reg;
  assign all_released = all_released_reg;
  assign cycle_count  = cycle_count_reg;

endmodule

// File: tb/tb_system_reset_sequencer.sv
// Scoreboard bench: three sequencer configurations driven by shared stimulus,
// expected outputs derived from the release-edge timing rules.
module tb_system_reset_sequencer;

  localparam int N  = 4;
  localparam int H  = 8;
  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] soft_rst_req;

  logic        sys_a, sys_b, sys_c;
  logic [3:0]  tile_a, tile_b, tile_c;
  logic        all_a, all_b, all_c;
  logic [31:0] cnt_a, cnt_c;
  logic [3:0]  cnt_b;

  system_reset_sequencer #(.NUM_TILES(4), .SYNC_STAGES(2), .HOLD_CYCLES(8),
                           .STAGGER_CYCLES(2), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .sys_rst(sys_a),
    .tile_rst(tile_a), .all_released(all_a), .cycle_count(cnt_a));

  system_reset_sequencer #(.NUM_TILES(4), .SYNC_STAGES(2), .HOLD_CYCLES(8),
                           .STAGGER_CYCLES(2), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .sys_rst(sys_b),
    .tile_rst(tile_b), .all_released(all_b), .cycle_count(cnt_b));

  system_reset_sequencer #(.NUM_TILES(4), .SYNC_STAGES(2), .HOLD_CYCLES(8),
                           .STAGGER_CYCLES(0), .CNT_WIDTH(32)) dut_c (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .sys_rst(sys_c),
    .tile_rst(tile_c), .all_released(all_c), .cycle_count(cnt_c));

  typedef struct {
    int         dut;
    int         en;
    logic       sys;
    logic [3:0] tile;
    logic       all;
    longint     cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t async_q[$];
  event async_ev;

  int checks   = 0;
  int failures = 0;

  // Reference state: edges seen since release, and per-tile soft-reset end edge.
  int     edge_no = 0;
  int     soft_end[3][4];
  int     gap[3]  = '{2, 2, 0};
  longint cmax[3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};

  function automatic int run_edge(int d);
    return SS + H + gap[d] * N;
  endfunction

  function automatic exp_t expect_for(int d);
    exp_t r;
    int   e;
    int   erel;
    e     = edge_no;
    erel  = SS + H;
    r.dut = d;
    r.en  = e;
    r.sys = (e < erel);
    for (int i = 0; i < N; i++) begin
      r.tile[i] = (e < erel + gap[d] * (i + 1)) || (e < soft_end[d][i]);
    end
    r.all = (e >= run_edge(d)) && (r.tile == 4'b0000);
    if (e > run_edge(d)) begin
      r.cnt = longint'(e - run_edge(d));
      if (r.cnt > cmax[d]) r.cnt = cmax[d];
    end else begin
      r.cnt = 0;
    end
    return r;
  endfunction

  task automatic model_reset();
    edge_no = 0;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < N; i++) soft_end[d][i] = 0;
  endtask

  task automatic model_edge(input logic rn, input logic [3:0] req);
    int prev;
    if (!rn) begin
      model_reset();
    end else begin
      prev    = edge_no;
      edge_no = edge_no + 1;
      for (int d = 0; d < 3; d++)
        for (int i = 0; i < N; i++)
          if (req[i] && prev >= run_edge(d)) soft_end[d][i] = edge_no + H;
    end
    for (int d = 0; d < 3; d++) exp_q.push_back(expect_for(d));
  endtask

  task automatic step(input logic rn, input logic [3:0] req);
    rst_n        = rn;
    soft_rst_req = req;
    model_edge(rn, req);
    @(negedge clk);
  endtask

  // Sub-cycle reset pulse placed between two rising edges.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) async_q.push_back(expect_for(d));
    -> async_ev;
    #2 rst_n = 1'b1;
    model_edge(1'b1, soft_rst_req);
    @(negedge clk);
  endtask

  task automatic compare(input exp_t r, input string tag);
    logic       a_sys, a_all;
    logic [3:0] a_tile;
    longint     a_cnt;
    case (r.dut)
      0:       begin a_sys = sys_a; a_tile = tile_a; a_all = all_a; a_cnt = longint'(cnt_a); end
      1:       begin a_sys = sys_b; a_tile = tile_b; a_all = all_b; a_cnt = longint'(cnt_b); end
      default: begin a_sys = sys_c; a_tile = tile_c; a_all = all_c; a_cnt = longint'(cnt_c); end
    endcase
    checks++;
    if (a_sys !== r.sys || a_tile !== r.tile || a_all !== r.all || a_cnt != r.cnt) begin
      failures++;
      $display("FAIL %s dut%0d edge=%0d got sys=%b tile=%b all=%b cnt=%0d want sys=%b tile=%b all=%b cnt=%0d",
               tag, r.dut, r.en, a_sys, a_tile, a_all, a_cnt, r.sys, r.tile, r.all, r.cnt);
    end
  endtask

  initial begin : monitor_edge
    exp_t r;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        compare(r, "outputs");
      end
    end
  end

  initial begin : monitor_async
    exp_t r;
    forever begin
      @(async_ev);
      while (async_q.size() > 0) begin
        r = async_q.pop_front();
        compare(r, "async_reset");
      end
    end
  end

  initial begin : driver
    rst_n        = 1'b0;
    soft_rst_req = '0;
    model_reset();
    @(negedge clk);
    repeat (3) step(1'b0, 4'b0000);

    // Plain release; CNT_WIDTH=4 instance saturates during the following runs.
    repeat (30) step(1'b1, 4'b0000);
    step(1'b1, 4'b0100);
    repeat (12) step(1'b1, 4'b0000);
    step(1'b1, 4'b1001);
    repeat (4) step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);
    repeat (15) step(1'b1, 4'b0000);

    // Short reset pulse mid-stagger, then a full repeat of the sequence.
    step(1'b0, 4'b0000);
    repeat (13) step(1'b1, 4'b0000);
    pulse_reset();
    repeat (25) step(1'b1, 4'b0000);

    // Requests held high before RUN.
    repeat (2) step(1'b0, 4'b0000);
    repeat (18) step(1'b1, 4'b1111);
    repeat (20) step(1'b1, 4'b0000);

    for (int r = 0; r < 8; r++) begin
      int         len;
      logic [3:0] q;
      repeat ($urandom_range(1, 3)) step(1'b0, 4'b0000);
      len = $urandom_range(15, 70);
      for (int k = 0; k < len; k++) begin
        for (int i = 0; i < N; i++) q[i] = ($urandom_range(0, 7) == 0);
        step(1'b1, q);
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_reset();
        repeat ($urandom_range(2, 20)) step(1'b1, 4'b0000);
      end
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || async_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d want pending=0", exp_q.size() + async_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
